// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decoder and the program sequencer.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned OFFS_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned SP_W = $clog2(DEPTH + 1);

  logic              stall;
  logic              branch;
  logic              call;
  logic              ret;
  logic [OFFS_W-1:0] offset;
  logic              clr_err;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  // Decoder side: issues flow requests, observes fetch address and stack status.
  modport master (
    output stall, branch, call, ret, offset, clr_err,
    input  pc, sp, full, empty, overflow, underflow
  );

  // Sequencer side.
  modport slave (
    input  stall, branch, call, ret, offset, clr_err,
    output pc, sp, full, empty, overflow, underflow
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: PC, PC-relative target adder and return-address stack.
module pc_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned OFFS_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);
  localparam int unsigned SP_W  = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] target;
  logic [SP_W-1:0]   sp_q;
  logic [SP_W-1:0]   sp_d;
  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
  logic              push;
  logic              ovf_q;
  logic              ovf_d;
  logic              unf_q;
  logic              unf_d;

  // Return address and sign-extended relative target, both wrapping modulo 2^ADDR_W.
  assign ret_addr = pc_q + ADDR_W'(1);
  assign target   = pc_q + ADDR_W'($signed(bus.offset));
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
  assign push_idx = IDX_W'(sp_q);

  // Next-state decode: one action per cycle, ret > call > branch > increment.
  always_comb begin
    pc_d  = ret_addr;
    sp_d  = sp_q;
    push  = 1'b0;
    ovf_d = ovf_q & ~bus.clr_err;
    unf_d = unf_q & ~bus.clr_err;
    if (bus.ret) begin
      if (sp_q != '0) begin
        pc_d = stack_q[top_idx];
        sp_d = sp_q - SP_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (bus.call) begin
      if (sp_q != SP_FULL) begin
        push = 1'b1;
        pc_d = target;
        sp_d = sp_q + SP_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (bus.branch) begin
      pc_d = target;
    end
  end

  // State registers; stall freezes everything including error clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= ADDR_W'(RESET_PC);
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (!bus.stall) begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push) begin
        stack_q[push_idx] <= ret_addr;
      end
    end
  end

  // Status outputs; full/empty decode directly from the stack pointer.
  assign bus.pc        = pc_q;
  assign bus.sp        = sp_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.full      = (sp_q == SP_FULL);
  assign bus.empty     = (sp_q == '0);
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program sequencer that generalises the processor's program counter, PC-relative adder and call/return stack into one block. Each cycle it produces the next fetch address. Supported flow operations: sequential increment, conditional relative branch, call and return. The return-address stack has a configurable depth with full/empty status and sticky overflow/underflow error flags. A stall input freezes all state. The block sits between the decoder/ALU zero flag and the instruction ROM address input.

Parameters:
ADDR_W, 8, width of PC, return addresses and stack entries
OFFS_W, 8, width of signed branch/call offset (two's complement, OFFS_W <= ADDR_W)
DEPTH, 4, number of return-address stack entries (>= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC, stack and flags for this cycle
branch  in  1  take relative branch (decoder condition AND zero already applied)
call  in  1  push return address, jump relative
ret  in  1  pop return address into PC
offset  in  OFFS_W  signed relative offset for branch/call
clr_err  in  1  clear sticky error flags
pc  out  ADDR_W  current fetch address (registered)
sp  out  clog2(DEPTH+1)  number of valid stack entries
full  out  1  sp == DEPTH (combinational from sp)
empty  out  1  sp == 0 (combinational from sp)
overflow  out  1  sticky: call attempted while full
underflow  out  1  sticky: ret attempted while empty

Behaviour:
- Reset (async, any time, including mid-operation): pc=RESET_PC, sp=0, overflow=0, underflow=0, all stack entries=0. full=0, empty=1.
- All state updates occur on the rising clk edge. pc reflects the operation one cycle after the control inputs are sampled (latency 1).
- Target arithmetic: offset is sign-extended to ADDR_W; target = pc + sext(offset), modulo 2^ADDR_W (wrap, no flag). Return address = pc + 1, modulo 2^ADDR_W.
- stall=1: pc, sp, stack and flags hold. All other inputs are ignored, including clr_err.
- Priority when stall=0 (exactly one action per cycle): ret > call > branch > increment.
  - ret, sp>0: pc <= stack[sp-1]; sp <= sp-1.
  - ret, sp==0: underflow <= 1; pc <= pc+1; sp unchanged.
  - call, sp<DEPTH: stack[sp] <= pc+1; sp <= sp+1; pc <= target.
  - call, sp==DEPTH: overflow <= 1; pc <= pc+1; no push, no jump.
  - branch: pc <= target.
  - none: pc <= pc+1.
- Lower-priority requests asserted in the same cycle are dropped, not queued.
- Stack is LIFO. Entries at index >= sp are don't-care for reads but are never read.
- clr_err=1 (not stalled) clears both flags. If an error event occurs in the same cycle, the set wins and the flag reads 1 next cycle.
- PC wrap: pc = 2^ADDR_W-1 with increment gives 0. A call at that address pushes 0.

Test Plan:
- Reset then 5 idle cycles -> pc 0,1,2,3,4,5; sp=0, empty=1; reset asserted mid-count (async, between edges) -> pc=0 immediately, flags 0.
- pc=10, branch=1, offset=8'hFB (-5) -> next pc=5; pc=250, branch, offset=+10 -> pc=4 (wrap).
- pc=3, call offset=+7 -> pc=10, sp=1, stack[0]=4; nested call at pc=12 offset=+20 -> pc=32, sp=2; ret -> pc=13; ret -> pc=4, sp=0, empty=1.
- DEPTH=4: five successive calls -> sp=4, full=1; fifth call sets overflow=1, pc advances by 1, sp stays 4; ret with sp=0 sets underflow=1, pc+1; clr_err -> both 0.
- ret, call and branch asserted together with sp=1, stack[0]=40 -> pc=40, sp=0, no push; call+branch together -> call taken, sp increments.
- stall=1 for 3 cycles during call/ret/branch requests -> pc, sp, flags unchanged; clr_err during stall leaves flags set; operation resumes correctly after stall drops.
